// File: rtl/ipm2t_hssthp_lpll_lock_ctrl_v1_0.sv
// Lane-PLL bring-up supervisor: sequences the LPLL reset, qualifies lock, monitors it, retries on fault.
// Optional macro IPM2T_LPLL_AUTO_RETRY_EN enables bounded automatic retries; otherwise any fault goes to FAIL.
module ipm2t_hssthp_lpll_lock_ctrl_v1_0 #(
    parameter int unsigned FREE_CLOCK_FREQ      = 100,
    parameter int unsigned RST_PULSE_CYCLES     = 16,
    parameter int unsigned DONE_TIMEOUT_US      = 100,
    parameter int unsigned STABLE_US            = 10,
    parameter int unsigned LOSS_DEBOUNCE_CYCLES = 8,
    parameter int unsigned MAX_RETRY            = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pll_lock,
    input  logic       lpll_done,
    input  logic       restart,
    output logic       lpll_seq_rst_n,
    output logic       lane_rst,
    output logic       lpll_ready,
    output logic       lock_loss,
    output logic       lock_fail,
    output logic [3:0] retry_cnt
);

    localparam int unsigned DONE_TO    = DONE_TIMEOUT_US * FREE_CLOCK_FREQ;
    localparam int unsigned STABLE_CYC = STABLE_US * FREE_CLOCK_FREQ;

    localparam logic [23:0] RST_LAST    = 24'(RST_PULSE_CYCLES - 1);
    localparam logic [23:0] DONE_LAST   = 24'(DONE_TO - 1);
    localparam logic [23:0] STABLE_LAST = 24'(STABLE_CYC - 1);
    localparam logic [23:0] LOSS_LAST   = 24'(LOSS_DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]  RETRY_MAX   = 4'(MAX_RETRY);

`ifdef IPM2T_LPLL_AUTO_RETRY_EN
    localparam bit AUTO_RETRY = 1'b1;
`else
    localparam bit AUTO_RETRY = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RST,
        WAIT_DONE,
        STABLE,
        READY,
        FAIL
    } state_t;

    state_t      state;
    logic [23:0] cnt;
    logic [23:0] cnt_inc;
    logic        do_retry;
    logic        retry_ok;

    assign cnt_inc  = (cnt == '1) ? cnt : cnt + 24'd1;
    assign retry_ok = AUTO_RETRY && (retry_cnt < RETRY_MAX);

    // In READY the cycle counter doubles as the consecutive-low debounce count.
    always_comb begin
        do_retry = 1'b0;
        case (state)
            WAIT_DONE: do_retry = !lpll_done && (cnt >= DONE_LAST);
            STABLE:    do_retry = !pll_lock;
            READY:     do_retry = !pll_lock && (cnt >= LOSS_LAST);
            default:   do_retry = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= '0;
            lpll_seq_rst_n <= 1'b0;
            lane_rst       <= 1'b1;
            lpll_ready     <= 1'b0;
            lock_loss      <= 1'b0;
            lock_fail      <= 1'b0;
            retry_cnt      <= '0;
        end else begin
            lock_loss <= 1'b0;
            if (restart) begin
                state          <= RST;
                cnt            <= '0;
                lpll_seq_rst_n <= 1'b0;
                lane_rst       <= 1'b1;
                lpll_ready     <= 1'b0;
                lock_fail      <= 1'b0;
                retry_cnt      <= '0;
            end else if (do_retry) begin
                // Lock-loss pulse coincides with ready dropping, whatever the retry outcome.
                lock_loss      <= (state == READY);
                cnt            <= '0;
                lpll_seq_rst_n <= 1'b0;
                lane_rst       <= 1'b1;
                lpll_ready     <= 1'b0;
                if (retry_ok) begin
                    state     <= RST;
                    retry_cnt <= retry_cnt + 4'd1;
                end else begin
                    state     <= FAIL;
                    lock_fail <= 1'b1;
                end
            end else begin
                case (state)
                    IDLE: begin
                        state          <= RST;
                        cnt            <= '0;
                        lpll_seq_rst_n <= 1'b0;
                        lane_rst       <= 1'b1;
                        lpll_ready     <= 1'b0;
                    end
                    RST: begin
                        if (cnt >= RST_LAST) begin
                            state          <= WAIT_DONE;
                            cnt            <= '0;
                            lpll_seq_rst_n <= 1'b1;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    WAIT_DONE: begin
                        if (lpll_done) begin
                            state <= STABLE;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    STABLE: begin
                        if (cnt >= STABLE_LAST) begin
                            state      <= READY;
                            cnt        <= '0;
                            lpll_ready <= 1'b1;
                            lane_rst   <= 1'b0;
                            retry_cnt  <= '0;
                        end else begin
                            cnt <= cnt_inc;
                        end
                    end
                    READY: begin
                        cnt <= pll_lock ? '0 : cnt_inc;
                    end
                    FAIL: begin
                        cnt <= cnt_inc;
                    end
                    default: begin
                        state <= IDLE;
                        cnt   <= '0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_ipm2t_hssthp_lpll_lock_ctrl_v1_0.sv
// Bench for the LPLL lock supervisor; expectations come from parameter arithmetic and a small retry-budget model.
`timescale 1ns/1ps
module tb_ipm2t_hssthp_lpll_lock_ctrl_v1_0;

    localparam int unsigned FCF = 1;
    localparam int unsigned RPC = 4;
    localparam int unsigned DTU = 50;
    localparam int unsigned SU  = 10;
    localparam int unsigned LDC = 3;
    localparam int unsigned MR  = 2;
    localparam int unsigned DTO = DTU * FCF;
    localparam int unsigned SC  = SU * FCF;

`ifdef IPM2T_LPLL_AUTO_RETRY_EN
    localparam bit AUTO = 1'b1;
`else
    localparam bit AUTO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll_lock = 1'b0;
    logic       lpll_done = 1'b0;
    logic       restart = 1'b0;
    logic       lpll_seq_rst_n;
    logic       lane_rst;
    logic       lpll_ready;
    logic       lock_loss;
    logic       lock_fail;
    logic [3:0] retry_cnt;

    int checks = 0;
    int errors = 0;

    // Retry-budget model: retries used and whether the budget is exhausted.
    int exp_retry = 0;
    bit exp_fail  = 1'b0;

    ipm2t_hssthp_lpll_lock_ctrl_v1_0 #(
        .FREE_CLOCK_FREQ(FCF),
        .RST_PULSE_CYCLES(RPC),
        .DONE_TIMEOUT_US(DTU),
        .STABLE_US(SU),
        .LOSS_DEBOUNCE_CYCLES(LDC),
        .MAX_RETRY(MR)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pll_lock(pll_lock),
        .lpll_done(lpll_done),
        .restart(restart),
        .lpll_seq_rst_n(lpll_seq_rst_n),
        .lane_rst(lane_rst),
        .lpll_ready(lpll_ready),
        .lock_loss(lock_loss),
        .lock_fail(lock_fail),
        .retry_cnt(retry_cnt)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        repeat (n) step();
    endtask

    task automatic model_fault();
        if (AUTO && exp_retry < int'(MR)) exp_retry++;
        else exp_fail = 1'b1;
    endtask

    task automatic model_clear();
        exp_retry = 0;
        exp_fail  = 1'b0;
    endtask

    task automatic wait_seq(input logic level, output int n, output bit ok);
        n = 0;
        while (lpll_seq_rst_n !== level && n < 2000) begin
            step();
            n++;
        end
        ok = (lpll_seq_rst_n === level);
    endtask

    task automatic wait_ready(output int n, output bit ok);
        n = 0;
        while (lpll_ready !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
        ok = (lpll_ready === 1'b1);
    endtask

    task automatic reset_dut();
        rst = 1'b1; restart = 1'b0; lpll_done = 1'b0; pll_lock = 1'b0;
        steps(2);
        rst = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        int n; bit ok;
        rst = 1'b1; restart = 1'b1; lpll_done = 1'b1; pll_lock = 1'b1;
        steps(3);
        checks++;
        if ({lpll_seq_rst_n, lane_rst, lpll_ready, lock_loss, lock_fail, retry_cnt} !== 9'h080) begin
            errors++;
            $display("FAIL reset_values: got %b expected %b",
                     {lpll_seq_rst_n, lane_rst, lpll_ready, lock_loss, lock_fail, retry_cnt}, 9'h080);
        end
        rst = 1'b0; restart = 1'b0; lpll_done = 1'b0;
        model_clear();
        step();
        wait_seq(1'b1, n, ok);
        checks++;
        if (n != int'(RPC)) begin
            errors++;
            $display("FAIL reset_pulse_len: got %0d expected %0d", n, RPC);
        end
    endtask

    task automatic test_nominal();
        int n, m, k; bit ok, seq_ok;
        for (int it = 0; it < 2; it++) begin
            reset_dut();
            pll_lock = 1'b1;
            step();
            wait_seq(1'b1, n, ok);
            checks++;
            if (n != int'(RPC)) begin
                errors++;
                $display("FAIL nominal_pulse_len: got %0d expected %0d", n, RPC);
            end
            // Second pass puts done exactly on the timeout cycle; done must win.
            k = (it == 0) ? int'($urandom_range(DTO - 2, 0)) : int'(DTO - 1);
            steps(k);
            lpll_done = 1'b1;
            m = 0; seq_ok = 1'b1;
            while (lpll_ready !== 1'b1 && m < 2000) begin
                step();
                m++;
                if (lpll_seq_rst_n !== 1'b1) seq_ok = 1'b0;
            end
            checks++;
            if (!seq_ok) begin
                errors++;
                $display("FAIL nominal_seq_held: got seq_rst_n low expected high (k=%0d)", k);
            end
            checks++;
            if (m != int'(1 + SC)) begin
                errors++;
                $display("FAIL nominal_ready_latency: got %0d expected %0d (k=%0d)", m, 1 + SC, k);
            end
            checks++;
            if (lane_rst !== 1'b0) begin
                errors++;
                $display("FAIL nominal_lane_rst: got %b expected 0", lane_rst);
            end
            checks++;
            if (retry_cnt !== 4'(exp_retry)) begin
                errors++;
                $display("FAIL nominal_retry_cnt: got %0d expected %0d", retry_cnt, exp_retry);
            end
        end
    endtask

    task automatic test_timeout();
        int n, t; bit ok;
        reset_dut();
        pll_lock = 1'($urandom_range(1, 0));
        step();
        wait_seq(1'b1, n, ok);
        for (int a = 0; a <= int'(MR) + 1; a++) begin
            wait_seq(1'b0, t, ok);
            checks++;
            if (t != int'(DTO)) begin
                errors++;
                $display("FAIL timeout_len: got %0d expected %0d (attempt %0d)", t, DTO, a);
            end
            model_fault();
            checks++;
            if (retry_cnt !== 4'(exp_retry) || lock_fail !== exp_fail) begin
                errors++;
                $display("FAIL timeout_retry: got retry=%0d fail=%b expected retry=%0d fail=%b",
                         retry_cnt, lock_fail, exp_retry, exp_fail);
            end
            if (exp_fail) begin
                steps(2 * RPC + 4);
                checks++;
                if ({lpll_seq_rst_n, lock_fail, lane_rst} !== 3'b011) begin
                    errors++;
                    $display("FAIL fail_hold: got seq/fail/lane=%b expected 011",
                             {lpll_seq_rst_n, lock_fail, lane_rst});
                end
                break;
            end
            wait_seq(1'b1, n, ok);
            checks++;
            if (n != int'(RPC)) begin
                errors++;
                $display("FAIL retry_pulse_len: got %0d expected %0d", n, RPC);
            end
        end
    endtask

    task automatic test_debounce();
        int n, g; bit ok, clean;
        reset_dut();
        step();
        wait_seq(1'b1, n, ok);
        pll_lock = 1'b1; lpll_done = 1'b1;
        wait_ready(n, ok);
        model_clear();
        // Two sub-window glitches separated by a single high cycle must both be ignored.
        g = int'($urandom_range(LDC - 1, 1));
        clean = 1'b1;
        pll_lock = 1'b0;
        for (int i = 0; i < g; i++) begin step(); if (lpll_ready !== 1'b1 || lock_loss !== 1'b0) clean = 1'b0; end
        pll_lock = 1'b1;
        step();
        if (lpll_ready !== 1'b1 || lock_loss !== 1'b0) clean = 1'b0;
        pll_lock = 1'b0;
        for (int i = 0; i < g; i++) begin step(); if (lpll_ready !== 1'b1 || lock_loss !== 1'b0) clean = 1'b0; end
        pll_lock = 1'b1;
        for (int i = 0; i < int'(LDC) + 2; i++) begin step(); if (lpll_ready !== 1'b1 || lock_loss !== 1'b0) clean = 1'b0; end
        checks++;
        if (!clean) begin
            errors++;
            $display("FAIL debounce_glitch: got ready drop or loss pulse expected none (g=%0d)", g);
        end
        pll_lock = 1'b0;
        steps(LDC - 1);
        checks++;
        if ({lpll_ready, lock_loss} !== 2'b10) begin
            errors++;
            $display("FAIL debounce_early: got ready/loss=%b expected 10", {lpll_ready, lock_loss});
        end
        step();
        model_fault();
        lpll_done = 1'b0;
        checks++;
        if ({lock_loss, lpll_ready, lane_rst, lpll_seq_rst_n} !== 4'b1010) begin
            errors++;
            $display("FAIL debounce_loss: got loss/ready/lane/seq=%b expected 1010",
                     {lock_loss, lpll_ready, lane_rst, lpll_seq_rst_n});
        end
        checks++;
        if (retry_cnt !== 4'(exp_retry) || lock_fail !== exp_fail) begin
            errors++;
            $display("FAIL debounce_retry: got retry=%0d fail=%b expected retry=%0d fail=%b",
                     retry_cnt, lock_fail, exp_retry, exp_fail);
        end
        step();
        checks++;
        if (lock_loss !== 1'b0) begin
            errors++;
            $display("FAIL debounce_pulse_width: got %b expected 0", lock_loss);
        end
    endtask

    task automatic test_unstable();
        int n, m; bit ok;
        reset_dut();
        step();
        wait_seq(1'b1, n, ok);
        pll_lock = 1'b1; lpll_done = 1'b1;
        step();
        steps(5);
        pll_lock = 1'b0;
        step();
        model_fault();
        lpll_done = 1'b0; pll_lock = 1'b1;
        checks++;
        if ({lpll_seq_rst_n, lpll_ready, retry_cnt, lock_fail} !== {1'b0, 1'b0, 4'(exp_retry), exp_fail}) begin
            errors++;
            $display("FAIL unstable_retry: got seq/ready/retry/fail=%b expected %b",
                     {lpll_seq_rst_n, lpll_ready, retry_cnt, lock_fail},
                     {1'b0, 1'b0, 4'(exp_retry), exp_fail});
        end
        if (!exp_fail) begin
            wait_seq(1'b1, n, ok);
            lpll_done = 1'b1;
            wait_ready(m, ok);
            model_clear();
            checks++;
            if (m != int'(1 + SC)) begin
                errors++;
                $display("FAIL unstable_restab_len: got %0d expected %0d", m, 1 + SC);
            end
            checks++;
            if (retry_cnt !== 4'(exp_retry)) begin
                errors++;
                $display("FAIL unstable_retry_clear: got %0d expected %0d", retry_cnt, exp_retry);
            end
        end
    endtask

    task automatic test_restart();
        int n, d; bit ok;
        reset_dut();
        step();
        wait_seq(1'b1, n, ok);
        n = 0;
        while (lock_fail !== 1'b1 && n < 2000) begin step(); n++; end
        checks++;
        if (lock_fail !== 1'b1) begin
            errors++;
            $display("FAIL restart_reach_fail: got %b expected 1", lock_fail);
        end
        steps(3);
        restart = 1'b1;
        step();
        restart = 1'b0;
        model_clear();
        checks++;
        if ({lock_fail, retry_cnt, lpll_seq_rst_n, lpll_ready, lane_rst} !== 8'b0_0000_001) begin
            errors++;
            $display("FAIL restart_from_fail: got fail/retry/seq/ready/lane=%b expected 00000001",
                     {lock_fail, retry_cnt, lpll_seq_rst_n, lpll_ready, lane_rst});
        end
        wait_seq(1'b1, n, ok);
        checks++;
        if (n != int'(RPC)) begin
            errors++;
            $display("FAIL restart_pulse_len: got %0d expected %0d", n, RPC);
        end
        d = int'($urandom_range(10, 0));
        steps(d);
        lpll_done = 1'b1; restart = 1'b1;
        step();
        restart = 1'b0; lpll_done = 1'b0;
        wait_seq(1'b1, n, ok);
        checks++;
        if (n != int'(RPC)) begin
            errors++;
            $display("FAIL restart_over_done: got low len %0d expected %0d", n, RPC);
        end
        pll_lock = 1'b1; lpll_done = 1'b1;
        wait_ready(n, ok);
        restart = 1'b1;
        step();
        restart = 1'b0; lpll_done = 1'b0;
        checks++;
        if ({lpll_ready, lane_rst, lpll_seq_rst_n} !== 3'b010) begin
            errors++;
            $display("FAIL restart_in_ready: got ready/lane/seq=%b expected 010",
                     {lpll_ready, lane_rst, lpll_seq_rst_n});
        end
        wait_seq(1'b1, n, ok);
        lpll_done = 1'b1;
        wait_ready(n, ok);
        rst = 1'b1; restart = 1'b1;
        step();
        checks++;
        if ({lpll_seq_rst_n, lane_rst, lpll_ready, lock_loss, lock_fail, retry_cnt} !== 9'h080) begin
            errors++;
            $display("FAIL rst_over_restart: got %b expected %b",
                     {lpll_seq_rst_n, lane_rst, lpll_ready, lock_loss, lock_fail, retry_cnt}, 9'h080);
        end
        rst = 1'b0; restart = 1'b0; lpll_done = 1'b0;
        step();
        wait_seq(1'b1, n, ok);
        checks++;
        if (n != int'(RPC)) begin
            errors++;
            $display("FAIL rst_restart_pulse_len: got %0d expected %0d", n, RPC);
        end
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_timeout();
        test_debounce();
        test_unstable();
        test_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "watchdog");
    end

endmodule
